// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//   Types and helpers used by the SPI register-file peripheral.
//   - spi_state_e : frame FSM states (IDLE/CMD/DATA/HOLD)
//   - RW_WRITE    : value of the frame's first bit that selects a write
//   - frame_w()   : total frame length in bits (1 R/W + address + data)
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } spi_state_e;

    localparam logic RW_WRITE = 1'b1;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
//   Multi-flop synchroniser for one asynchronous input, with rise/fall pulse
//   detection on the last synchronised stage against one history flop.
//   Ports:
//     clk_i   system clock
//     rst_i   synchronous active-high reset (clears all flops to 0)
//     async_i asynchronous input pin
//     sync_o  synchronised level
//     rise_o  one-cycle pulse when sync_o goes 0->1
//     fall_o  one-cycle pulse when sync_o goes 1->0
// ---------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// ---------------------------------------------------------------------------
// spi_regfile_peripheral
//   SPI mode-0 peripheral exposing NUM_REGS registers of DATA_W bits.
//   Frame (MSB first): R/W bit (1 = write), ADDR_W address bits, DATA_W data
//   bits. Writes commit when nCS rises after exactly a full frame; reads drive
//   the addressed register on CIPO during the data phase.
//   Ports:
//     clk, rst           system clock, synchronous active-high reset
//     nCS, SCLK, COPI    asynchronous SPI pins (synchronised internally)
//     CIPO, cipo_oe      registered read data and pad output enable
//     regs_out           flattened registers, reg i at [i*DATA_W +: DATA_W]
//     wr_strobe, wr_addr one-cycle pulse and address of a committed write
//     frame_err          sticky flag: a frame ended with the wrong bit count
//     state_dbg          current FSM state (spi_state_e encoding)
//
//   Handshake: the SPI side has no backpressure. A write is accepted exactly
//   when wr_strobe is high for one clk cycle; wr_addr is valid only in that
//   cycle, and regs_out already shows the new value in that same cycle.
// ---------------------------------------------------------------------------
module spi_regfile_peripheral
    import spi_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       nCS,
    input  logic                       SCLK,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err,
    output logic [1:0]                 state_dbg
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    // ---------------- input synchronisation ----------------
    logic ncs_s, ncs_rise, ncs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic copi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk_i(clk), .rst_i(rst), .async_i(nCS),
        .sync_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i(clk), .rst_i(rst), .async_i(SCLK),
        .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    // COPI uses the same depth as SCLK so a detected SCLK rise lines up with
    // the COPI value that was present at that pin edge.
    always_ff @(posedge clk) begin
        if (rst) copi_sync_q <= '0;
        else     copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
    end
    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    // ---------------- state ----------------
    spi_state_e                     state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [ADDR_W:0]                cmd_q, cmd_d, cmd_next;
    logic [DATA_W-1:0]              data_q, data_d;
    logic [DATA_W-1:0]              shout_q, shout_d;
    logic                           rw_q, rw_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic                           overrun_q, overrun_d;
    logic                           cipo_q, cipo_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic                           wr_strobe_q;
    logic [ADDR_W-1:0]              wr_addr_q;
    logic                           err_q;

    logic                           commit, err_set, addr_hit;
    logic [DATA_W-1:0]              rd_word;

    // Read lookup uses the address arriving with the last command bit;
    // out-of-range addresses read as zero.
    always_comb begin
        cmd_next = {cmd_q[ADDR_W-1:0], copi_s};
        rd_word  = '0;
        addr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_next[ADDR_W-1:0] == ADDR_W'(i)) rd_word  = regs_q[i];
            if (addr_q == ADDR_W'(i))               addr_hit = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        shout_d   = shout_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        overrun_d = overrun_q;
        cipo_d    = cipo_q;
        commit    = 1'b0;
        err_set   = 1'b0;

        // nCS rise ends any frame and takes priority over a same-cycle SCLK edge.
        if (state_q != ST_IDLE && ncs_rise) begin
            state_d = ST_IDLE;
            cipo_d  = 1'b0;
            commit  = (state_q == ST_HOLD) && !overrun_q && (rw_q == RW_WRITE) && addr_hit;
            err_set = (state_q != ST_HOLD) || overrun_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state_d   = ST_CMD;
                        cnt_d     = '0;
                        cmd_d     = '0;
                        data_d    = '0;
                        shout_d   = '0;
                        overrun_d = 1'b0;
                        cipo_d    = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        cmd_d = cmd_next;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(ADDR_W)) begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                            rw_d    = cmd_next[ADDR_W];
                            addr_d  = cmd_next[ADDR_W-1:0];
                            if (cmd_next[ADDR_W] != RW_WRITE) begin
                                shout_d = rd_word;
                                cipo_d  = rd_word[DATA_W-1];
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        data_d = {data_q[DATA_W-2:0], copi_s};
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_HOLD;
                    end else if (sclk_fall && cnt_q != '0) begin
                        // The fall right after the last command bit must not
                        // shift: the MSB is presented for the first data rise.
                        shout_d = shout_q << 1;
                        cipo_d  = shout_q[DATA_W-2];
                    end
                end
                ST_HOLD: begin
                    if (sclk_rise) overrun_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            shout_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            overrun_q   <= 1'b0;
            cipo_q      <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            shout_q     <= shout_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            overrun_q   <= overrun_d;
            cipo_q      <= cipo_d;
            wr_strobe_q <= commit;
            err_q       <= err_q | err_set;
            if (commit) wr_addr_q <= addr_q;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && addr_q == ADDR_W'(i)) regs_q[i] <= data_q;
            end
        end
    end

    assign CIPO      = cipo_q;
    assign cipo_oe   = (state_q != ST_IDLE);
    assign regs_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
module tb_spi_regfile_peripheral;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;
  localparam int HALF     = 5;  // SCLK half period in clk cycles

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ncs = 1'b1;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic cipo, cipo_oe, wr_strobe, frame_err;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  spi_regfile_peripheral #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .nCS(ncs), .SCLK(sclk), .COPI(copi),
    .CIPO(cipo), .cipo_oe(cipo_oe), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] obs_q[$];

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) obs_q.push_back(wr_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drain_scoreboard(input string name);
    logic [ADDR_W-1:0] a, e;
    check({name, "_strobe_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      a = obs_q.pop_front();
      e = exp_q.pop_front();
      check({name, "_wr_addr"}, 64'(a), 64'(e));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic smp);
    copi = b;
    wait_clk(HALF);
    smp  = cipo;  // controller samples CIPO just before its rising edge
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic run_frame(input int nbits, input logic [31:0] frame, output logic [DATA_W-1:0] rd);
    logic smp;
    rd  = '0;
    ncs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == 3) begin
        check("cmd_phase_oe", 64'(cipo_oe), 64'd1);
        check("cmd_phase_cipo", 64'(cipo), 64'd0);
      end
      spi_bit(frame[nbits-1-i], smp);
      if (i >= 1 + ADDR_W && i < 1 + ADDR_W + DATA_W) rd = {rd[DATA_W-2:0], smp};
    end
    wait_clk(HALF);
    ncs  = 1'b1;
    copi = 1'b0;
    wait_clk(10);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_regs"}, 64'(regs_out), 64'd0);
    check({name, "_cipo"}, 64'(cipo), 64'd0);
    check({name, "_oe"}, 64'(cipo_oe), 64'd0);
    check({name, "_strobe"}, 64'(wr_strobe), 64'd0);
    check({name, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({name, "_err"}, 64'(frame_err), 64'd0);
    check({name, "_state"}, 64'(state_dbg), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string                      name;
    logic [15:0]                frame;
    logic                       is_rd;
    logic                       exp_strobe;
    logic [ADDR_W-1:0]          exp_addr;
    logic [DATA_W-1:0]          exp_rd;
    logic [NUM_REGS*DATA_W-1:0] exp_regs;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [15:0] f, input logic r,
                              input logic s, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input logic [NUM_REGS*DATA_W-1:0] g);
    vec_t v;
    v.name = n; v.frame = f; v.is_rd = r; v.exp_strobe = s;
    v.exp_addr = a; v.exp_rd = d; v.exp_regs = g;
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    logic [DATA_W-1:0] rd;
    logic smp;
    logic [31:0] fr;

    // regs packed as {reg4, reg3, reg2, reg1, reg0}
    vecs[0]  = mk("wr_r0_F0",    16'h80F0, 1'b0, 1'b1, 7'd0, 8'h00, 40'h00_00_00_00_F0);
    vecs[1]  = mk("wr_r4_80",    16'h8480, 1'b0, 1'b1, 7'd4, 8'h00, 40'h80_00_00_00_F0);
    vecs[2]  = mk("rd_r4",       16'h0400, 1'b1, 1'b0, 7'd0, 8'h80, 40'h80_00_00_00_F0);
    vecs[3]  = mk("rd_r0",       16'h0000, 1'b1, 1'b0, 7'd0, 8'hF0, 40'h80_00_00_00_F0);
    vecs[4]  = mk("wr_bad_7F",   16'hFF55, 1'b0, 1'b0, 7'd0, 8'h00, 40'h80_00_00_00_F0);
    vecs[5]  = mk("rd_bad_7F",   16'h7F00, 1'b1, 1'b0, 7'd0, 8'h00, 40'h80_00_00_00_F0);
    vecs[6]  = mk("wr_r2_A5",    16'h82A5, 1'b0, 1'b1, 7'd2, 8'h00, 40'h80_00_A5_00_F0);
    vecs[7]  = mk("rd_r2",       16'h0200, 1'b1, 1'b0, 7'd0, 8'hA5, 40'h80_00_A5_00_F0);
    vecs[8]  = mk("wr_bad_1C",   16'h9C11, 1'b0, 1'b0, 7'd0, 8'h00, 40'h80_00_A5_00_F0);
    vecs[9]  = mk("wr_r1_33",    16'h8133, 1'b0, 1'b1, 7'd1, 8'h00, 40'h80_00_A5_33_F0);
    vecs[10] = mk("rd_r1",       16'h0100, 1'b1, 1'b0, 7'd0, 8'h33, 40'h80_00_A5_33_F0);
    vecs[11] = mk("rd_r4_copi1", 16'h04FF, 1'b1, 1'b0, 7'd0, 8'h80, 40'h80_00_A5_33_F0);

    do_reset();
    wait_clk(6);
    check_reset_state("reset");
    drain_scoreboard("reset");

    foreach (vecs[k]) begin
      if (vecs[k].exp_strobe) exp_q.push_back(vecs[k].exp_addr);
      run_frame(16, 32'(vecs[k].frame), rd);
      check({vecs[k].name, "_regs"}, 64'(regs_out), 64'(vecs[k].exp_regs));
      check({vecs[k].name, "_err"}, 64'(frame_err), 64'd0);
      check({vecs[k].name, "_state"}, 64'(state_dbg), 64'd0);
      check({vecs[k].name, "_oe"}, 64'(cipo_oe), 64'd0);
      if (vecs[k].is_rd) check({vecs[k].name, "_rd"}, 64'(rd), 64'(vecs[k].exp_rd));
      drain_scoreboard(vecs[k].name);
    end

    // Truncated 15-bit write to addr 1: dropped, error flagged and sticky.
    fr = 32'h0000_81AA >> 1;
    run_frame(15, fr, rd);
    check("trunc_regs", 64'(regs_out), 64'h80_00_A5_33_F0);
    check("trunc_err", 64'(frame_err), 64'd1);
    drain_scoreboard("trunc");
    run_frame(16, 32'h0000_0000, rd);
    check("trunc_sticky_err", 64'(frame_err), 64'd1);
    check("trunc_follow_rd", 64'(rd), 64'hF0);
    drain_scoreboard("trunc_follow");

    // Reset while idle clears everything, including the sticky error.
    do_reset();
    check_reset_state("reset2");

    // Fresh write to reg2, then a 17-bit overrun write to reg2.
    exp_q.push_back(7'd2);
    run_frame(16, 32'h0000_825A, rd);
    check("r2_5A_regs", 64'(regs_out), 64'h00_00_5A_00_00);
    drain_scoreboard("r2_5A");
    fr = (32'h0000_82C3 << 1) | 32'd1;
    run_frame(17, fr, rd);
    check("overrun_regs", 64'(regs_out), 64'h00_00_5A_00_00);
    check("overrun_err", 64'(frame_err), 64'd1);
    drain_scoreboard("overrun");

    // Reset asserted after 10 bits of a write to reg3.
    fr  = 32'h0000_833C;
    ncs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 10; i++) spi_bit(fr[15-i], smp);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
    check_reset_state("midreset");
    ncs = 1'b1;
    wait_clk(10);
    check("midreset_idle_regs", 64'(regs_out), 64'd0);
    drain_scoreboard("midreset");

    exp_q.push_back(7'd3);
    run_frame(16, fr, rd);
    check("r3_3C_regs", 64'(regs_out), 64'h00_3C_00_00_00);
    check("r3_3C_err", 64'(frame_err), 64'd0);
    drain_scoreboard("r3_3C");

    // A few random valid writes with a read-back each.
    for (int n = 0; n < 4; n++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      d = DATA_W'($urandom_range(0, 255));
      exp_q.push_back(a);
      fr = {16'h0, 1'b1, a, d};
      run_frame(16, fr, rd);
      check("rand_wr_reg", 64'(regs_out[a*DATA_W +: DATA_W]), 64'(d));
      drain_scoreboard("rand_wr");
      fr = {16'h0, 1'b0, a, 8'h00};
      run_frame(16, fr, rd);
      check("rand_rd", 64'(rd), 64'(d));
      drain_scoreboard("rand_rd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
